// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and
// memory chip-select levels (the chip select is active-low).
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WR_LO  = 3'd2,
        WR_HI  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } loader_state_e;

    localparam logic MEM_CS_ON  = 1'b0;
    localparam logic MEM_CS_OFF = 1'b1;

    function automatic logic is_busy_state(input loader_state_e s);
        return (s == ACCEPT) || (s == WR_LO) || (s == WR_HI);
    endfunction

endpackage

// File: rtl/program_loader.sv
// Streams 16-bit instruction words into byte-wide memory (low byte first) and
// releases the CPU reset once the image is complete. Optional running checksum
// is built only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 128
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          In_Valid,
    output logic          In_Ready,
    input  logic [15:0]   In_Data,
    input  logic          In_Last,
    output logic          Mem_CS,
    output logic          Mem_WR,
    output logic [15:0]   Mem_Address,
    output logic [7:0]    Mem_Data,
    output logic          Cpu_Reset,
    output logic          Busy,
    output logic          Done,
    output logic          Error,
    output logic [7:0]    Checksum,
    output loader_state_e Dbg_State
);

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    // Handshake: a word moves on a rising edge where In_Valid and In_Ready are
    // both high. In_Ready is decoded from state only (never from In_Valid), and
    // the sender holds In_Data/In_Last stable until the word is taken.

    loader_state_e state, state_next;
    logic [15:0]   word_q;
    logic          last_q;
    logic [15:0]   count;
    logic [15:0]   pointer;
    logic          transfer;

    logic          cs_d;
    logic          wr_d;
    logic [15:0]   addr_d;
    logic [7:0]    data_d;

    assign In_Ready  = (state == ACCEPT);
    assign transfer  = In_Ready && In_Valid;
    assign Dbg_State = state;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = ACCEPT;
            ACCEPT: begin
                if (transfer) state_next = (count < MAX_W) ? WR_LO : ERR;
            end
            WR_LO:   state_next = WR_HI;
            WR_HI:   state_next = last_q ? DONE : ACCEPT;
            DONE:    state_next = DONE;
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    // Memory outputs are registered from the next state so each strobe lines
    // up exactly with the WR_LO / WR_HI cycle. A WR_LO entry only comes from an
    // ACCEPT transfer, so the low byte is taken straight from In_Data.
    always_comb begin
        cs_d   = MEM_CS_OFF;
        wr_d   = 1'b0;
        addr_d = 16'h0000;
        data_d = 8'h00;
        case (state_next)
            WR_LO: begin
                cs_d   = MEM_CS_ON;
                wr_d   = 1'b1;
                addr_d = pointer;
                data_d = In_Data[7:0];
            end
            WR_HI: begin
                cs_d   = MEM_CS_ON;
                wr_d   = 1'b1;
                addr_d = pointer + 16'd1;
                data_d = word_q[15:8];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Mem_CS      <= MEM_CS_OFF;
            Mem_WR      <= 1'b0;
            Mem_Address <= 16'h0000;
            Mem_Data    <= 8'h00;
            Cpu_Reset   <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Error       <= 1'b0;
        end else begin
            Mem_CS      <= cs_d;
            Mem_WR      <= wr_d;
            Mem_Address <= addr_d;
            Mem_Data    <= data_d;
            Cpu_Reset   <= (state_next == DONE);
            Busy        <= is_busy_state(state_next);
            Done        <= (state_next == DONE);
            Error       <= (state_next == ERR);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            word_q  <= 16'h0000;
            last_q  <= 1'b0;
            count   <= 16'h0000;
            pointer <= BASE_ADDR;
        end else begin
            if (state == IDLE && Start) begin
                count   <= 16'h0000;
                pointer <= BASE_ADDR;
            end
            if (transfer && count < MAX_W) begin
                word_q <= In_Data;
                last_q <= In_Last;
            end
            // Pointer wraps modulo 2^16 by plain truncation.
            if (state == WR_HI) begin
                pointer <= pointer + 16'd2;
                count   <= count + 16'd1;
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] checksum_q;

    // Mem_Data holds the byte being written during WR_LO / WR_HI.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            checksum_q <= 8'h00;
        end else if (state == IDLE && Start) begin
            checksum_q <= 8'h00;
        end else if (state == WR_LO || state == WR_HI) begin
            checksum_q <= checksum_q + Mem_Data;
        end
    end

    assign Checksum = checksum_q;
`else
    assign Checksum = 8'h00;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (default parameters, and a wrapping
// base address with a two-word limit) driven by one stimulus stream.
module tb_program_loader;
    import loader_pkg::*;

    localparam logic [15:0] BASE_A = 16'h0000;
    localparam int          MAX_A  = 128;
    localparam logic [15:0] BASE_B = 16'hFFFE;
    localparam int          MAX_B  = 2;

    logic Clock, Reset, Start, In_Valid, In_Last;
    logic [15:0] In_Data;

    logic In_Ready_a, Mem_CS_a, Mem_WR_a, Cpu_Reset_a, Busy_a, Done_a, Error_a;
    logic [15:0] Mem_Address_a;
    logic [7:0] Mem_Data_a, Checksum_a;
    loader_state_e Dbg_State_a;

    logic In_Ready_b, Mem_CS_b, Mem_WR_b, Cpu_Reset_b, Busy_b, Done_b, Error_b;
    logic [15:0] Mem_Address_b;
    logic [7:0] Mem_Data_b, Checksum_b;
    loader_state_e Dbg_State_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rec = 0;

    logic [23:0] got_a_q[$], got_b_q[$], exp_a_q[$], exp_b_q[$];
    logic [15:0] img[$];
    int rdy_a_q[$], rdy_b_q[$], cs_cyc_q[$];
    logic [7:0] exp_ck_a, exp_ck_b;
    bit exp_err_b;

    program_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(MAX_A)) dut_a (
        .Clock(Clock), .Reset(Reset), .Start(Start), .In_Valid(In_Valid),
        .In_Ready(In_Ready_a), .In_Data(In_Data), .In_Last(In_Last),
        .Mem_CS(Mem_CS_a), .Mem_WR(Mem_WR_a), .Mem_Address(Mem_Address_a),
        .Mem_Data(Mem_Data_a), .Cpu_Reset(Cpu_Reset_a), .Busy(Busy_a),
        .Done(Done_a), .Error(Error_a), .Checksum(Checksum_a), .Dbg_State(Dbg_State_a)
    );

    program_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(MAX_B)) dut_b (
        .Clock(Clock), .Reset(Reset), .Start(Start), .In_Valid(In_Valid),
        .In_Ready(In_Ready_b), .In_Data(In_Data), .In_Last(In_Last),
        .Mem_CS(Mem_CS_b), .Mem_WR(Mem_WR_b), .Mem_Address(Mem_Address_b),
        .Mem_Data(Mem_Data_b), .Cpu_Reset(Cpu_Reset_b), .Busy(Busy_b),
        .Done(Done_b), .Error(Error_b), .Checksum(Checksum_b), .Dbg_State(Dbg_State_b)
    );

    // Clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitors, sampled on the falling edge
    always @(negedge Clock) begin
        if (Reset === 1'b1 && Mem_CS_a === MEM_CS_ON) begin
            got_a_q.push_back({Mem_Address_a, Mem_Data_a});
            cs_cyc_q.push_back(cyc);
            chk("mem_wr_a", Mem_WR_a, 1);
        end
        if (Reset === 1'b1 && Mem_CS_b === MEM_CS_ON) begin
            got_b_q.push_back({Mem_Address_b, Mem_Data_b});
            chk("mem_wr_b", Mem_WR_b, 1);
        end
        if (rec && In_Ready_a) rdy_a_q.push_back(cyc);
        if (rec && In_Ready_b) rdy_b_q.push_back(cyc);
    end

    // Reference model: one word becomes two byte writes at base+2i, base+2i+1;
    // words beyond the limit are never written and flag an error.
    task automatic model_load();
        logic [15:0] a;
        exp_a_q.delete();
        exp_b_q.delete();
        exp_ck_a = 8'h00;
        exp_ck_b = 8'h00;
        for (int i = 0; i < img.size(); i++) begin
            if (i < MAX_A) begin
                a = 16'(int'(BASE_A) + 2 * i);
                exp_a_q.push_back({a, img[i][7:0]});
                exp_a_q.push_back({16'(a + 16'd1), img[i][15:8]});
                exp_ck_a = 8'(exp_ck_a + img[i][7:0] + img[i][15:8]);
            end
            if (i < MAX_B) begin
                a = 16'(int'(BASE_B) + 2 * i);
                exp_b_q.push_back({a, img[i][7:0]});
                exp_b_q.push_back({16'(a + 16'd1), img[i][15:8]});
                exp_ck_b = 8'(exp_ck_b + img[i][7:0] + img[i][15:8]);
            end
        end
        exp_err_b = (img.size() > MAX_B);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        exp_ck_a = 8'h00;
        exp_ck_b = 8'h00;
`endif
    endtask

    task automatic clear_obs();
        got_a_q.delete();
        got_b_q.delete();
        cs_cyc_q.delete();
        rdy_a_q.delete();
        rdy_b_q.delete();
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, "_nwr_a"}, got_a_q.size(), exp_a_q.size());
        for (int i = 0; i < exp_a_q.size(); i++)
            if (i < got_a_q.size()) chk({tag, "_wr_a"}, got_a_q[i], exp_a_q[i]);
        chk({tag, "_nwr_b"}, got_b_q.size(), exp_b_q.size());
        for (int i = 0; i < exp_b_q.size(); i++)
            if (i < got_b_q.size()) chk({tag, "_wr_b"}, got_b_q[i], exp_b_q[i]);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rdy_a"}, In_Ready_a, 0);
        chk({tag, "_cs_a"}, Mem_CS_a, 1);
        chk({tag, "_wr_a"}, Mem_WR_a, 0);
        chk({tag, "_addr_a"}, Mem_Address_a, 0);
        chk({tag, "_data_a"}, Mem_Data_a, 0);
        chk({tag, "_cpu_a"}, Cpu_Reset_a, 0);
        chk({tag, "_flags_a"}, {Busy_a, Done_a, Error_a}, 0);
        chk({tag, "_ck_a"}, Checksum_a, 0);
        chk({tag, "_st_a"}, Dbg_State_a, IDLE);
        chk({tag, "_cs_b"}, Mem_CS_b, 1);
        chk({tag, "_flags_b"}, {Busy_b, Done_b, Error_b, Cpu_Reset_b}, 0);
        chk({tag, "_st_b"}, Dbg_State_b, IDLE);
    endtask

    // Driver tasks
    task automatic do_reset();
        @(posedge Clock); #1;
        Reset = 1'b0;
        Start = 1'b0;
        In_Valid = 1'b0;
        In_Last = 1'b0;
        #1 check_reset_vals("reset");
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
        clear_obs();
    endtask

    task automatic pulse_start();
        @(posedge Clock); #1 Start = 1'b1;
        @(posedge Clock); #1 Start = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge Clock);
        while (!In_Ready_a && k < 20) begin
            @(negedge Clock);
            k++;
        end
        if (!In_Ready_a) chk("ready_timeout", In_Ready_a, 1);
        @(posedge Clock); #1;
    endtask

    task automatic send_word(input logic [15:0] w, input bit last, input bit hold);
        In_Data = w;
        In_Last = last;
        In_Valid = 1'b1;
        wait_ready();
        if (!hold) begin
            In_Valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge Clock);
            #1;
        end
    endtask

    task automatic wait_settle();
        int k = 0;
        while (!(Done_a || Error_a) && k < 30) begin
            @(negedge Clock);
            k++;
        end
        chk("settle_timeout", Done_a || Error_a, 1);
        repeat (2) @(negedge Clock);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_done_a"}, Done_a, 1);
        chk({tag, "_err_a"}, Error_a, 0);
        chk({tag, "_cpu_a"}, Cpu_Reset_a, 1);
        chk({tag, "_busy_a"}, Busy_a, 0);
        chk({tag, "_ck_a"}, Checksum_a, exp_ck_a);
        chk({tag, "_done_b"}, Done_b, !exp_err_b);
        chk({tag, "_err_b"}, Error_b, exp_err_b);
        chk({tag, "_cpu_b"}, Cpu_Reset_b, !exp_err_b);
        chk({tag, "_busy_b"}, Busy_b, 0);
        chk({tag, "_ck_b"}, Checksum_b, exp_ck_b);
    endtask

    task automatic run_img(input string tag, input bit hold);
        model_load();
        pulse_start();
        for (int i = 0; i < img.size(); i++)
            send_word(img[i], i == img.size() - 1, hold);
        In_Valid = 1'b0;
        In_Last = 1'b0;
        wait_settle();
        check_status(tag);
        compare_writes(tag);
    endtask

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(16'($urandom));
    endtask

    // Directed sequence
    initial begin
        logic [15:0] w;
        Reset = 1'b0;
        Start = 1'b0;
        In_Valid = 1'b0;
        In_Last = 1'b0;
        In_Data = 16'h0000;

        // Reference image: two words, second last
        do_reset();
        img.delete();
        img.push_back(16'h1A05);
        img.push_back(16'h7C33);
        run_img("basic", 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk("basic_ck_const", Checksum_a, 8'hCE);
`endif

        // In_Valid held high over four words: one word per three cycles
        do_reset();
        fill_random(4);
        rec = 1'b1;
        run_img("stream", 1'b1);
        rec = 1'b0;
        chk("stream_nrdy_a", rdy_a_q.size(), 4);
        for (int i = 1; i < rdy_a_q.size(); i++)
            chk("stream_rdy_gap", rdy_a_q[i] - rdy_a_q[i-1], 3);
        chk("stream_nrdy_b", rdy_b_q.size(), 3);
        chk("stream_ncs", cs_cyc_q.size(), 8);
        for (int i = 0; i < rdy_a_q.size(); i++) begin
            if (2 * i + 1 < cs_cyc_q.size()) begin
                chk("stream_lo_lat", cs_cyc_q[2*i] - rdy_a_q[i], 1);
                chk("stream_hi_lat", cs_cyc_q[2*i+1] - rdy_a_q[i], 2);
            end
        end

        // Random images with random gaps
        for (int t = 0; t < 4; t++) begin
            do_reset();
            fill_random($urandom_range(1, 5));
            run_img("rand", 1'b0);
        end

        // Reset during the high-byte write of word 0
        do_reset();
        w = 16'($urandom);
        pulse_start();
        In_Data = w;
        In_Last = 1'b0;
        In_Valid = 1'b1;
        wait_ready();
        In_Valid = 1'b0;
        @(posedge Clock); #2;
        Reset = 1'b0;
        #1;
        chk("midrst_cs_a", Mem_CS_a, 1);
        chk("midrst_cs_b", Mem_CS_b, 1);
        chk("midrst_st_a", Dbg_State_a, IDLE);
        @(posedge Clock); #1 Reset = 1'b1;
        In_Valid = 1'b1;
        repeat (6) @(posedge Clock);
        #1 In_Valid = 1'b0;
        chk("midrst_idle_a", Dbg_State_a, IDLE);
        chk("midrst_rdy_a", In_Ready_a, 0);
        exp_a_q.delete();
        exp_b_q.delete();
        exp_a_q.push_back({BASE_A, w[7:0]});
        exp_b_q.push_back({BASE_B, w[7:0]});
        compare_writes("midrst");

        // Start pulses in ACCEPT and in DONE are ignored
        do_reset();
        fill_random(2);
        model_load();
        pulse_start();
        send_word(img[0], 1'b0, 1'b0);
        repeat (3) @(posedge Clock);
        #1;
        chk("start_acc_st", Dbg_State_a, ACCEPT);
        pulse_start();
        send_word(img[1], 1'b1, 1'b0);
        In_Valid = 1'b0;
        In_Last = 1'b0;
        wait_settle();
        check_status("startign");
        compare_writes("startign");
        clear_obs();
        pulse_start();
        repeat (3) @(negedge Clock);
        chk("start_done_st", Dbg_State_a, DONE);
        chk("start_done_ck", Checksum_a, exp_ck_a);
        chk("start_done_cpu", Cpu_Reset_a, 1);
        chk("start_done_nwr", got_a_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0000, meaning the memory byte address of the first loaded byte.
REQ-002 SHALL have parameter MAX_WORDS, default 128, meaning the maximum number of 16-bit words per load (range 1..32767).
REQ-003 SHALL have ports (clock and reset first, name / direction / width / meaning):
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse that begins a load.
- In_Valid  in  1  In_Data and In_Last are valid.
- In_Ready  out  1  loader accepts a word this cycle.
- In_Data  in  16  instruction word; [7:0] is the low byte.
- In_Last  in  1  marks the final word of the image.
- Mem_CS  out  1  memory chip select, active-low.
- Mem_WR  out  1  1 = write.
- Mem_Address  out  16  memory byte address.
- Mem_Data  out  8  write data byte.
- Cpu_Reset  out  1  active-low hold to the CPU (CPUSystem Reset).
- Busy  out  1  load in progress.
- Done  out  1  load completed successfully; sticky.
- Error  out  1  MAX_WORDS exceeded; sticky.
- Checksum  out  8  running byte checksum.
REQ-004 SHALL sample Reset asynchronously as active-low and Clock on its rising edge, as already decided.

Function
REQ-005 SHALL implement states IDLE, ACCEPT, WR_LO, WR_HI, DONE and ERR.
REQ-006 SHALL move IDLE->ACCEPT on Start=1; this clears the word count and checksum and sets the pointer to BASE_ADDR.
REQ-007 SHALL drive In_Ready=1 only in ACCEPT; a word transfers on In_Valid & In_Ready. In_Valid outside ACCEPT is ignored.
REQ-008 SHALL, on transfer in ACCEPT while count<MAX_WORDS, latch In_Data and In_Last and go to WR_LO.
REQ-009 SHALL, in WR_LO, drive Mem_CS=0, Mem_WR=1, Mem_Address=pointer, Mem_Data=word[7:0] for exactly one cycle, then go to WR_HI.
REQ-010 SHALL, in WR_HI, drive Mem_CS=0, Mem_WR=1, Mem_Address=pointer+1, Mem_Data=word[15:8] for one cycle.
REQ-011 SHALL, after WR_HI, add 2 to the pointer and 1 to the count; go to DONE if the latched In_Last=1, else to ACCEPT.
REQ-012 SHALL, in all other states, drive Mem_CS=1, Mem_WR=0, Mem_Address=16'h0000, Mem_Data=8'h00.
REQ-013 SHALL have latency: word accepted in cycle N, low-byte write in N+1, high-byte write in N+2, In_Ready=1 again in N+3 (one word per 3 cycles).
REQ-014 SHALL, on transfer while count==MAX_WORDS, perform no write and go to ERR.
REQ-015 SHALL compute the pointer modulo 2^16; address wrap past 16'hFFFF continues silently at 16'h0000.
REQ-016 SHALL hold Cpu_Reset=0 in every state except DONE; Cpu_Reset=1 only in DONE.
REQ-017 SHALL drive Busy=1 in ACCEPT, WR_LO and WR_HI; Done=1 in DONE; Error=1 in ERR.
REQ-018 SHALL ignore Start outside IDLE; DONE and ERR exit only via Reset.
REQ-019 SHALL register all outputs, with no combinational path from inputs to outputs except In_Ready, which is state-decoded only.

Reset
REQ-020 SHALL, on Reset=0, immediately force state IDLE, In_Ready=0, Mem_CS=1, Mem_WR=0, Mem_Address=0, Mem_Data=0, Cpu_Reset=0, Busy=0, Done=0, Error=0, Checksum=0, count=0, pointer=BASE_ADDR.
REQ-021 SHALL, if Reset asserts mid-write, abandon the pending byte with no further memory access after release.

Configuration
REQ-022 SHALL, when macro PROGRAM_LOADER_CHECKSUM_EN is defined, update Checksum = (Checksum + byte) mod 256 in each WR_LO and WR_HI cycle, visible the following cycle.
REQ-023 SHALL, when PROGRAM_LOADER_CHECKSUM_EN is undefined, tie Checksum to 8'h00 and synthesize no adder.

Structure
REQ-024 SHALL place the state enum typedef and the MEM_CS_ON/MEM_CS_OFF constants in shared package loader_pkg.
REQ-025 SHALL be a single module with no sub-modules; the checksum adder is inline under the macro.

Verification
REQ-026 Reset then Start; words 16'h1A05, 16'h7C33 (last) -> writes 00:05, 01:1A, 02:33, 03:7C; Done=1; Cpu_Reset=1; Checksum=8'hCE with macro.
REQ-027 In_Valid held 1 with 4 words -> In_Ready high every third cycle only; exactly 8 single-cycle Mem_CS=0 pulses.
REQ-028 MAX_WORDS=2; send 3 words, none last -> 4 writes, third word ignored, Error=1, Cpu_Reset=0.
REQ-029 BASE_ADDR=16'hFFFE; 2 words -> addresses FFFE, FFFF, 0000, 0001.
REQ-030 Reset asserted during WR_HI of word 0 -> Mem_CS=1 immediately; after release, state IDLE, no writes until Start.
REQ-031 Start pulsed during ACCEPT and in DONE -> no effect on pointer, count or Checksum.
